ll_op_sequencer: RTL



---
 rtl/ll_op_sequencer_pkg.sv | 32 +++
 rtl/ll_op_sequencer_if.sv | 27 ++
 rtl/ll_op_sequencer_sw_sync.sv | 49 ++++
 rtl/ll_op_sequencer.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/ll_op_sequencer_pkg.sv
// ll_pkg: shared encodings for the linked-list front-end sequencer.
//   op_e     : command opcodes presented on cmd_op
//   status_e : completion status returned with done
//   state_e  : sequencer FSM states
package ll_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned OP_W       = 2;
  localparam int unsigned STATUS_W   = 2;

  typedef enum logic [OP_W-1:0] {
    OP_INS_HEAD = 2'b00,
    OP_INS_TAIL = 2'b01,
    OP_DELETE   = 2'b10,
    OP_TRAVERSE = 2'b11
  } op_e;

  typedef enum logic [STATUS_W-1:0] {
    ST_OK       = 2'd0,
    ST_FULL     = 2'd1,
    ST_EMPTY    = 2'd2,
    ST_NOTFOUND = 2'd3
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_SHOW  = 2'd3
  } state_e;

endpackage

// File: rtl/ll_op_sequencer_if.sv
// Command / traverse link between the sequencer (master) and the list core (slave).
//   cmd_valid/cmd_op/cmd_data : command request, held until cmd_ready
//   cmd_ready                 : core accepts on cmd_valid && cmd_ready
//   done/status               : one-cycle completion pulse with status
//   trav_valid/trav_data      : traverse stream, head first
interface ll_op_sequencer_if #(
  parameter int unsigned DATA_W = 8
);
  logic              cmd_valid;
  logic [1:0]        cmd_op;
  logic [DATA_W-1:0] cmd_data;
  logic              cmd_ready;
  logic              done;
  logic [1:0]        status;
  logic              trav_valid;
  logic [DATA_W-1:0] trav_data;

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, done, status, trav_valid, trav_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, done, status, trav_valid, trav_data
  );
endinterface

// File: rtl/ll_op_sequencer_sw_sync.sv
// ll_sw_sync: multi-stage synchronizer for the opcode/data switches plus the
// arm/edge detector that turns a 000 -> 1xx opcode change into one command.
//   clk, rst      : clock, async active-high reset
//   op_in/data_in : raw switch fields
//   take_c        : sequencer consumed the current edge (clears armed)
//   op_s/data_s   : synchronized fields
//   edge_c        : armed and synchronized opcode is 1xx
module ll_sw_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned SW_DATA_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           op_in,
  input  logic [SW_DATA_W-1:0] data_in,
  input  logic                 take_c,
  output logic [2:0]           op_s,
  output logic [SW_DATA_W-1:0] data_s,
  output logic                 edge_c
);

  localparam int unsigned W = 3 + SW_DATA_W;

  logic [W-1:0]           pipe [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] primed;
  logic                   armed;

  assign {op_s, data_s} = pipe[SYNC_STAGES-1];
  assign edge_c         = armed && op_s[2];

  // primed tracks reset-value flush so a post-reset zero in the pipe cannot arm
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) pipe[i] <= '0;
      primed <= '0;
      armed  <= 1'b0;
    end else begin
      pipe[0] <= {op_in, data_in};
      for (int unsigned i = 1; i < SYNC_STAGES; i++) pipe[i] <= pipe[i-1];
      primed <= SYNC_STAGES'({primed, 1'b1});
      if (take_c) begin
        armed <= 1'b0;
      end else if (primed[SYNC_STAGES-1] && op_s == 3'b000) begin
        armed <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ll_op_sequencer.sv
// ll_op_sequencer: board front-end for the linked-list core. Issues one
// handshaked command per switch opcode edge, tracks status on led, buffers a
// traverse stream and paces it onto the display.
//   clk, btnC          : clock, async active-high reset
//   sw                 : [15:13] opcode, [7:0] data
//   bus (master)       : command / completion / traverse link to the core
//   disp_valid/value   : value for the seven-segment driver
//   led                : [0] overflow sticky, [1] underflow sticky
//   busy               : FSM not idle
module ll_op_sequencer
  import ll_pkg::*;
#(
  parameter int unsigned NUM_NODES   = 4,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned HOLD_CYCLES = 50_000_000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              btnC,
  input  logic [15:0]       sw,
  ll_op_sequencer_if.master bus,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_value,
  output logic [1:0]        led,
  output logic              busy
);

  localparam int unsigned CNT_W  = $clog2(NUM_NODES + 1);
  localparam int unsigned IDX_W  = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  NODES_C   = CNT_W'(NUM_NODES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  state_e            state;
  op_e               op_q;
  logic [DATA_W-1:0] data_q;
  logic              cmd_valid_q;
  logic [CNT_W-1:0]  count;
  logic [IDX_W-1:0]  idx;
  logic [HOLD_W-1:0] hold_cnt;
  logic [DATA_W-1:0] tbuf [NUM_NODES];

  logic [2:0]        op_s;
  logic [7:0]        data_s;
  logic              edge_c;
  logic              take_c;
  logic              beat_c;
  logic              beat_store_c;
  logic              beat_drop_c;
  logic [CNT_W-1:0]  count_nxt_c;
  logic [1:0]        led_nxt_c;
  logic              unused_sw;

  assign unused_sw     = ^sw[12:8];
  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd_op    = op_q;
  assign bus.cmd_data  = data_q;

  ll_sw_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .SW_DATA_W   (8)
  ) u_sw_sync (
    .clk     (clk),
    .rst     (btnC),
    .op_in   (sw[15:13]),
    .data_in (sw[7:0]),
    .take_c  (take_c),
    .op_s    (op_s),
    .data_s  (data_s),
    .edge_c  (edge_c)
  );

  // Edge acceptance, traverse beat routing and next led value
  always_comb begin
    take_c       = edge_c && (state == S_IDLE || state == S_SHOW);
    beat_c       = (state == S_WAIT) && (op_q == OP_TRAVERSE) && bus.trav_valid;
    beat_store_c = beat_c && (count < NODES_C);
    beat_drop_c  = beat_c && !(count < NODES_C);
    count_nxt_c  = beat_store_c ? count + CNT_W'(1) : count;
    led_nxt_c    = led;
    if (beat_drop_c) led_nxt_c[0] = 1'b1;
    if (state == S_WAIT && bus.done) begin
      case (status_e'(bus.status))
        ST_OK:    led_nxt_c    = 2'b00;
        ST_FULL:  led_nxt_c[0] = 1'b1;
        ST_EMPTY: led_nxt_c[1] = 1'b1;
        default:  ;
      endcase
    end
  end

  // Sequencer FSM with traverse buffer and display pacing
  always_ff @(posedge clk or posedge btnC) begin
    if (btnC) begin
      state       <= S_IDLE;
      op_q        <= OP_INS_HEAD;
      data_q      <= '0;
      cmd_valid_q <= 1'b0;
      count       <= '0;
      idx         <= '0;
      hold_cnt    <= '0;
      disp_valid  <= 1'b0;
      disp_value  <= '0;
      led         <= 2'b00;
      busy        <= 1'b0;
      for (int unsigned i = 0; i < NUM_NODES; i++) tbuf[i] <= '0;
    end else begin
      led <= led_nxt_c;
      if (beat_store_c) begin
        tbuf[IDX_W'(count)] <= bus.trav_data;
        count               <= count_nxt_c;
      end
      if (take_c) begin
        // A new command also aborts any display in progress
        op_q        <= op_e'(op_s[1:0]);
        data_q      <= DATA_W'(data_s);
        cmd_valid_q <= 1'b1;
        busy        <= 1'b1;
        disp_valid  <= 1'b0;
        idx         <= '0;
        hold_cnt    <= '0;
        state       <= S_ISSUE;
        if (op_e'(op_s[1:0]) == OP_TRAVERSE) count <= '0;
      end else begin
        case (state)
          S_ISSUE: begin
            if (bus.cmd_ready) begin
              cmd_valid_q <= 1'b0;
              state       <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (bus.done) begin
              // count_nxt_c includes a beat arriving alongside done
              if (op_q == OP_TRAVERSE && count_nxt_c != '0) begin
                state      <= S_SHOW;
                disp_valid <= 1'b1;
                disp_value <= (count == '0) ? bus.trav_data : tbuf[0];
                idx        <= '0;
                hold_cnt   <= '0;
              end else begin
                state <= S_IDLE;
                busy  <= 1'b0;
              end
            end
          end
          S_SHOW: begin
            if (hold_cnt == HOLD_LAST) begin
              hold_cnt <= '0;
              if (CNT_W'(idx) + CNT_W'(1) == count) begin
                disp_valid <= 1'b0;
                idx        <= '0;
                state      <= S_IDLE;
                busy       <= 1'b0;
              end else begin
                idx        <= idx + IDX_W'(1);
                disp_value <= tbuf[idx + IDX_W'(1)];
              end
            end else begin
              hold_cnt <= hold_cnt + HOLD_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
